victim_writeback_buffer: RTL and testbench

- FIFO of dirty blocks evicted by the victim cache (its block_out path), downstream of the DM stage.
- Each entry pairs a 512-bit block with its 50-bit block address {ptag, vindex}; entries drain in order to the next memory level over a valid/ready handshake.
- A 1-cycle snoop port lets the miss path check for, and forward, a block still waiting in the buffer.
- Same-address evictions coalesce in place, so the buffer never holds duplicate addresses.

---
 rtl/victim_writeback_buffer_if.sv | 40 ++++
 rtl/victim_writeback_buffer.sv | 109 ++++++++++
 tb/tb_victim_writeback_buffer.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/victim_writeback_buffer_if.sv
// Handshake bundle for the victim writeback buffer: eviction intake, memory drain,
// snoop lookup and occupancy status.
interface victim_writeback_buffer_if #(
  parameter int DEPTH   = 4,
  parameter int ADDR_W  = 50,
  parameter int BLOCK_W = 512
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic               evict_valid;
  logic [ADDR_W-1:0]  evict_addr;
  logic [BLOCK_W-1:0] evict_block;
  logic               evict_ready;

  logic               mem_valid;
  logic [ADDR_W-1:0]  mem_addr;
  logic [BLOCK_W-1:0] mem_block;
  logic               mem_ready;

  logic               snoop_en;
  logic [ADDR_W-1:0]  snoop_addr;
  logic               snoop_hit;
  logic [BLOCK_W-1:0] snoop_block;

  logic [CNT_W-1:0]   count;
  logic               full;
  logic               empty;

  modport master (
    output evict_valid, evict_addr, evict_block, mem_ready, snoop_en, snoop_addr,
    input  evict_ready, mem_valid, mem_addr, mem_block, snoop_hit, snoop_block,
           count, full, empty
  );

  modport slave (
    input  evict_valid, evict_addr, evict_block, mem_ready, snoop_en, snoop_addr,
    output evict_ready, mem_valid, mem_addr, mem_block, snoop_hit, snoop_block,
           count, full, empty
  );
endinterface

// File: rtl/victim_writeback_buffer.sv
// In-order FIFO of dirty evicted blocks with same-address coalescing and a
// registered one-cycle snoop port for the miss path.
module victim_writeback_buffer #(
  parameter int DEPTH   = 4,
  parameter int ADDR_W  = 50,
  parameter int BLOCK_W = 512
) (
  input  logic                     clk,
  input  logic                     reset,
  victim_writeback_buffer_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0]  addr_q  [DEPTH];
  logic [BLOCK_W-1:0] block_q [DEPTH];
  logic [DEPTH-1:0]   valid_q;
  logic [PTR_W-1:0]   head_q, tail_q;
  logic [CNT_W-1:0]   count_q;
  logic               snoop_hit_q;
  logic [BLOCK_W-1:0] snoop_block_q;

  logic               full, empty, push_en, pop_en, coalesce, alloc;
  logic [DEPTH-1:0]   evict_match, snoop_match;
  logic [PTR_W-1:0]   match_idx;
  logic               snoop_any;
  logic [BLOCK_W-1:0] snoop_data;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign pop_en  = !empty && bus.mem_ready;
  assign push_en = bus.evict_valid && !full;
  assign alloc   = push_en && !coalesce;

  assign bus.evict_ready = !full;
  assign bus.mem_valid   = !empty;
  assign bus.mem_addr    = addr_q[head_q];
  assign bus.mem_block   = block_q[head_q];
  assign bus.count       = count_q;
  assign bus.full        = full;
  assign bus.empty       = empty;
  assign bus.snoop_hit   = snoop_hit_q;
  assign bus.snoop_block = snoop_block_q;

  // Coalescing keeps addresses unique, so both match vectors are at most one-hot
  // and can be reduced with a plain OR instead of a priority encoder.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    coalesce   = 1'b0;
    match_idx  = '0;
    snoop_any  = 1'b0;
    snoop_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      evict_match[i] = valid_q[i] && (addr_q[i] == bus.evict_addr) &&
                       !(pop_en && (head_q == PTR_W'(i)));
      snoop_match[i] = valid_q[i] && (addr_q[i] == bus.snoop_addr);
      if (evict_match[i]) begin
        coalesce  = 1'b1;
        match_idx = PTR_W'(i);
      end
      if (snoop_match[i]) begin
        snoop_any  = 1'b1;
        snoop_data = snoop_data | block_q[i];
      end
    end
  end

  // NOTE: the payload arrays carry no reset; valid_q alone decides what is live,
  // which keeps wide storage out of the reset tree.
  always_ff @(posedge clk) begin
    if (!reset && push_en) begin
      if (coalesce) begin
        block_q[match_idx] <= bus.evict_block;
      end else begin
        addr_q[tail_q]  <= bus.evict_addr;
        block_q[tail_q] <= bus.evict_block;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q       <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      snoop_hit_q   <= 1'b0;
      snoop_block_q <= '0;
    end else begin
      snoop_hit_q   <= bus.snoop_en && snoop_any;
      snoop_block_q <= bus.snoop_en ? snoop_data : '0;

      if (pop_en) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + PTR_W'(1);
      end
      // Pop and allocate never target the same slot: that needs count 0 or DEPTH.
      if (alloc) begin
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + PTR_W'(1);
      end

      if (alloc && !pop_en)      count_q <= count_q + CNT_W'(1);
      else if (!alloc && pop_en) count_q <= count_q - CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_victim_writeback_buffer.sv
// Self-checking bench for victim_writeback_buffer: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_victim_writeback_buffer;
  localparam int DEPTH   = 4;
  localparam int ADDR_W  = 50;
  localparam int BLOCK_W = 512;
  localparam int CNT_W   = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  victim_writeback_buffer_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .BLOCK_W(BLOCK_W)) bus ();

  victim_writeback_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .BLOCK_W(BLOCK_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: an ordered list of (address, block) pairs plus the expected
  // registered snoop result.
  logic [ADDR_W-1:0]  m_addr  [$];
  logic [BLOCK_W-1:0] m_block [$];
  logic               exp_hit;
  logic [BLOCK_W-1:0] exp_blk;

  function automatic logic [BLOCK_W-1:0] fill(input logic [7:0] b);
    return {(BLOCK_W/8){b}};
  endfunction

  function automatic logic [BLOCK_W-1:0] rand_block();
    logic [BLOCK_W-1:0] v;
    for (int k = 0; k < BLOCK_W/32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic idle_inputs();
    bus.evict_valid = 1'b0;
    bus.evict_addr  = '0;
    bus.evict_block = '0;
    bus.mem_ready   = 1'b0;
    bus.snoop_en    = 1'b0;
    bus.snoop_addr  = '0;
  endtask

  // Advance the model with the inputs present now, then let the DUT take the edge.
  task automatic tick();
    int  j;
    bit  pop, push;
    if (reset) begin
      m_addr.delete();
      m_block.delete();
      exp_hit = 1'b0;
      exp_blk = '0;
    end else begin
      push = bus.evict_valid && (m_addr.size() < DEPTH);
      pop  = bus.mem_ready && (m_addr.size() > 0);
      exp_hit = 1'b0;
      exp_blk = '0;
      if (bus.snoop_en)
        foreach (m_addr[k]) if (m_addr[k] == bus.snoop_addr) begin
          exp_hit = 1'b1;
          exp_blk = m_block[k];
        end
      j = -1;
      if (push)
        foreach (m_addr[k]) if (m_addr[k] == bus.evict_addr && !(pop && k == 0)) j = k;
      if (j >= 0) m_block[j] = bus.evict_block;
      if (pop) begin
        void'(m_addr.pop_front());
        void'(m_block.pop_front());
      end
      if (push && j < 0) begin
        m_addr.push_back(bus.evict_addr);
        m_block.push_back(bus.evict_block);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (bus.count !== '0) begin fails++; $display("FAIL reset_count: got %0d want 0", bus.count); end
    tests++; if (bus.empty !== 1'b1 || bus.full !== 1'b0) begin fails++; $display("FAIL reset_flags: empty=%b full=%b want 1 0", bus.empty, bus.full); end
    tests++; if (bus.evict_ready !== 1'b1 || bus.mem_valid !== 1'b0) begin fails++; $display("FAIL reset_handshake: evict_ready=%b mem_valid=%b want 1 0", bus.evict_ready, bus.mem_valid); end
    tests++; if (bus.snoop_hit !== 1'b0 || bus.snoop_block !== '0) begin fails++; $display("FAIL reset_snoop: hit=%b want 0, block nonzero=%b", bus.snoop_hit, |bus.snoop_block); end
  endtask

  task automatic test_fill_drain();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      bus.evict_valid = 1'b1;
      bus.evict_addr  = ADDR_W'(50'h100 + i);
      bus.evict_block = fill(8'(17 * (i + 1)));
      tick();
    end
    tests++; if (bus.count !== CNT_W'(4) || bus.full !== 1'b1 || bus.evict_ready !== 1'b0) begin
      fails++; $display("FAIL fill_full: count=%0d full=%b evict_ready=%b want 4 1 0", bus.count, bus.full, bus.evict_ready);
    end
    bus.evict_addr  = 50'h200;
    bus.evict_block = fill(8'h55);
    tick();
    tests++; if (bus.count !== CNT_W'(4)) begin fails++; $display("FAIL fill_fifth_refused: count=%0d want 4", bus.count); end
    bus.evict_valid = 1'b0;
    bus.mem_ready   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tests++; if (bus.mem_valid !== 1'b1 || bus.mem_addr !== ADDR_W'(50'h100 + i) || bus.mem_block !== fill(8'(17 * (i + 1)))) begin
        fails++; $display("FAIL drain_order[%0d]: valid=%b addr=%h want addr %h", i, bus.mem_valid, bus.mem_addr, 50'h100 + i);
      end
      tick();
    end
    tests++; if (bus.empty !== 1'b1 || bus.mem_valid !== 1'b0) begin fails++; $display("FAIL drain_empty: empty=%b mem_valid=%b want 1 0", bus.empty, bus.mem_valid); end
    idle_inputs();
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      bus.evict_valid = 1'b1; bus.evict_addr = ADDR_W'(50'h300 + i); bus.evict_block = fill(8'(i + 1));
      tick();
    end
    bus.evict_valid = 1'b0; bus.mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tests++; if (bus.mem_addr !== ADDR_W'(50'h300 + i)) begin fails++; $display("FAIL wrap_pop3[%0d]: addr=%h want %h", i, bus.mem_addr, 50'h300 + i); end
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      bus.evict_valid = 1'b1; bus.evict_addr = ADDR_W'(50'h310 + i); bus.evict_block = fill(8'(8'h80 + i));
      if (i > 0) begin
        tests++; if (bus.mem_valid !== 1'b1 || bus.mem_addr !== ADDR_W'(50'h310 + i - 1) || bus.mem_block !== fill(8'(8'h80 + i - 1))) begin
          fails++; $display("FAIL wrap_interleave[%0d]: valid=%b addr=%h want %h", i, bus.mem_valid, bus.mem_addr, 50'h310 + i - 1);
        end
        tests++; if (bus.count !== CNT_W'(1)) begin fails++; $display("FAIL wrap_count[%0d]: got %0d want 1", i, bus.count); end
      end
      tick();
    end
    bus.evict_valid = 1'b0;
    tests++; if (bus.mem_addr !== 50'h313) begin fails++; $display("FAIL wrap_last: addr=%h want 313", bus.mem_addr); end
    tick();
    tests++; if (bus.count !== '0 || bus.empty !== 1'b1) begin fails++; $display("FAIL wrap_final: count=%0d empty=%b want 0 1", bus.count, bus.empty); end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      bus.evict_valid = 1'b1; bus.evict_addr = ADDR_W'(50'h400 + i); bus.evict_block = fill(8'(8'hA0 + i));
      tick();
    end
    bus.evict_addr = 50'h402; bus.evict_block = fill(8'hA2); bus.mem_ready = 1'b1;
    tick();
    tests++; if (bus.count !== CNT_W'(2) || bus.mem_addr !== 50'h401) begin
      fails++; $display("FAIL push_pop_same: count=%0d head=%h want 2 401", bus.count, bus.mem_addr);
    end
    bus.evict_valid = 1'b0;
    tick(); tick();
    tests++; if (bus.empty !== 1'b1) begin fails++; $display("FAIL push_pop_drain: empty=%b want 1", bus.empty); end
    idle_inputs();
  endtask

  task automatic test_coalesce_snoop();
    logic [ADDR_W-1:0] a;
    a = 50'h1_0000_0000_01;
    do_reset();
    bus.evict_valid = 1'b1; bus.evict_addr = a; bus.evict_block = fill(8'hC1);
    tick();
    bus.evict_block = fill(8'hC2);
    tick();
    tests++; if (bus.count !== CNT_W'(1)) begin fails++; $display("FAIL coalesce_count: got %0d want 1", bus.count); end
    bus.evict_valid = 1'b0; bus.mem_ready = 1'b1;
    tests++; if (bus.mem_block !== fill(8'hC2)) begin fails++; $display("FAIL coalesce_data: got %h want c2..", bus.mem_block[7:0]); end
    tick();
    bus.mem_ready = 1'b0;
    bus.evict_valid = 1'b1; bus.evict_block = fill(8'hC1);
    tick();
    bus.evict_block = fill(8'hC2); bus.mem_ready = 1'b1;
    tests++; if (bus.mem_block !== fill(8'hC1)) begin fails++; $display("FAIL head_pop_old: got %h want c1..", bus.mem_block[7:0]); end
    tick();
    tests++; if (bus.count !== CNT_W'(1) || bus.mem_addr !== a || bus.mem_block !== fill(8'hC2)) begin
      fails++; $display("FAIL head_pop_alloc: count=%0d addr=%h blk=%h want 1 %h c2", bus.count, bus.mem_addr, bus.mem_block[7:0], a);
    end
    bus.evict_valid = 1'b0; bus.mem_ready = 1'b0;
    bus.snoop_en = 1'b1; bus.snoop_addr = a;
    tick();
    tests++; if (bus.snoop_hit !== 1'b1 || bus.snoop_block !== fill(8'hC2)) begin fails++; $display("FAIL snoop_hit: hit=%b blk=%h want 1 c2", bus.snoop_hit, bus.snoop_block[7:0]); end
    bus.snoop_addr = 50'h777;
    tick();
    tests++; if (bus.snoop_hit !== 1'b0 || bus.snoop_block !== '0) begin fails++; $display("FAIL snoop_miss: hit=%b blk=%h want 0 0", bus.snoop_hit, bus.snoop_block[7:0]); end
    bus.snoop_addr = a; bus.mem_ready = 1'b1;
    tick();
    tests++; if (bus.snoop_hit !== 1'b1 || bus.snoop_block !== fill(8'hC2) || bus.empty !== 1'b1) begin
      fails++; $display("FAIL snoop_during_pop: hit=%b blk=%h empty=%b want 1 c2 1", bus.snoop_hit, bus.snoop_block[7:0], bus.empty);
    end
    bus.snoop_en = 1'b0; bus.mem_ready = 1'b0;
    tick();
    tests++; if (bus.snoop_hit !== 1'b0 || bus.snoop_block !== '0) begin fails++; $display("FAIL snoop_disabled: hit=%b want 0", bus.snoop_hit); end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      bus.evict_valid = 1'b1; bus.evict_addr = ADDR_W'(50'h600 + i); bus.evict_block = fill(8'(8'hE0 + i));
      tick();
    end
    tests++; if (bus.count !== CNT_W'(3) || bus.mem_valid !== 1'b1) begin fails++; $display("FAIL mid_setup: count=%0d mem_valid=%b want 3 1", bus.count, bus.mem_valid); end
    bus.evict_addr = 50'h603; bus.mem_ready = 1'b1; bus.snoop_en = 1'b1; bus.snoop_addr = 50'h600;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.evict_valid = 1'b0; bus.snoop_en = 1'b0;
    tests++; if (bus.count !== '0 || bus.empty !== 1'b1 || bus.mem_valid !== 1'b0 || bus.snoop_hit !== 1'b0 || bus.evict_ready !== 1'b1) begin
      fails++; $display("FAIL mid_reset: count=%0d empty=%b mem_valid=%b hit=%b ready=%b want 0 1 0 0 1", bus.count, bus.empty, bus.mem_valid, bus.snoop_hit, bus.evict_ready);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++; if (bus.mem_valid !== 1'b0) begin fails++; $display("FAIL mid_stale[%0d]: mem_valid=%b want 0", i, bus.mem_valid); end
    end
    idle_inputs();
  endtask

  task automatic test_random();
    int sz;
    do_reset();
    for (int cyc = 0; cyc < 2000; cyc++) begin
      bus.evict_valid = ($urandom_range(0, 99) < 60);
      bus.evict_addr  = ADDR_W'(50'h1000 + $urandom_range(0, 5));
      bus.evict_block = rand_block();
      bus.mem_ready   = ($urandom_range(0, 99) < 45);
      bus.snoop_en    = ($urandom_range(0, 99) < 50);
      bus.snoop_addr  = ADDR_W'(50'h1000 + $urandom_range(0, 7));
      #1;
      sz = m_addr.size();
      tests++; if ({bus.count, bus.full, bus.empty, bus.evict_ready, bus.mem_valid} !==
                   {CNT_W'(sz), sz == DEPTH, sz == 0, sz != DEPTH, sz != 0}) begin
        fails++; $display("FAIL rnd_status@%0d: count=%0d full=%b empty=%b ready=%b valid=%b want count %0d", cyc, bus.count, bus.full, bus.empty, bus.evict_ready, bus.mem_valid, sz);
      end
      if (sz != 0) begin
        tests++; if (bus.mem_addr !== m_addr[0] || bus.mem_block !== m_block[0]) begin
          fails++; $display("FAIL rnd_head@%0d: addr=%h want %h", cyc, bus.mem_addr, m_addr[0]);
        end
      end
      tests++; if (bus.snoop_hit !== exp_hit || bus.snoop_block !== exp_blk) begin
        fails++; $display("FAIL rnd_snoop@%0d: hit=%b want %b, block match=%b", cyc, bus.snoop_hit, exp_hit, bus.snoop_block === exp_blk);
      end
      for (int i = 0; i < DEPTH; i++)
        for (int k = i + 1; k < DEPTH; k++) begin
          tests++; if (dut.valid_q[i] && dut.valid_q[k] && dut.addr_q[i] === dut.addr_q[k]) begin
            fails++; $display("FAIL rnd_unique@%0d: slots %0d and %0d both hold %h, want distinct", cyc, i, k, dut.addr_q[i]);
          end
        end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_fill_drain();
    test_wrap();
    test_back_to_back();
    test_coalesce_snoop();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
